// File: rtl/adb_host_seq.sv
// adb_host_seq: ADB host sequencer; drives st/command/listen bytes, collects Talk replies, runs autopoll.
// Latency: accept -> st=00 next clk_en cycle; Listen 3*PHASE_LEN+1, absent Talk PHASE_LEN+TIMEOUT+1 cycles to resp_valid.
// Backpressure: req_ready only in IDLE; device replies are paced by viaBusy and bounded by TIMEOUT.
module adb_host_seq #(
  parameter int PHASE_LEN     = 16,
  parameter int TIMEOUT       = 64,
  parameter int POLL_INTERVAL = 88000
) (
  input  logic        clk,
  input  logic        clk_en,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [15:0] req_data,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic [1:0]  resp_len,
  output logic        resp_timeout,
  output logic        resp_srq,
  output logic        resp_auto,
  input  logic        autopoll_en,
  input  logic [15:0] poll_mask,
  output logic [1:0]  st,
  output logic        viaBusy,
  output logic [7:0]  adb_din,
  output logic        adb_din_strobe,
  input  logic [7:0]  adb_dout,
  input  logic        adb_dout_strobe,
  input  logic        adb_int_n
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CMD  = 3'd1;
  localparam logic [2:0] EVEN = 3'd2;
  localparam logic [2:0] ODD  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  // Phase counter must reach TIMEOUT-1, which is the larger of the two phase limits.
  localparam int PW = $clog2(TIMEOUT + 1);
  localparam int IW = $clog2(POLL_INTERVAL + 1);
  localparam logic [PW-1:0] phaseLast   = PW'(PHASE_LEN - 1);
  localparam logic [PW-1:0] timeoutLast = PW'(TIMEOUT - 1);
  localparam logic [IW-1:0] pollLast    = IW'(POLL_INTERVAL - 1);

  logic [2:0]    state;
  logic [PW-1:0] phaseCnt;
  logic [IW-1:0] idleCnt;
  logic [15:0]   dataReg;
  logic          listenTxn;
  logic          talkTxn;
  logic          gotByte;
  logic [3:0]    pollAddr;
  logic [3:0]    nextPollAddr;
  logic [3:0]    cand;
  logic          found;
  logic          pollDue;
  logic          startTxn;
  logic [7:0]    startCmd;

  // A host request always beats an autopoll that comes due in the same cycle.
  assign pollDue   = autopoll_en && (idleCnt == pollLast);
  assign startTxn  = req_valid || pollDue;
  assign startCmd  = req_valid ? req_cmd : {pollAddr, 4'b1100};
  assign req_ready = (state == IDLE);

  // Bus state code follows the FSM state directly, so it holds while clk_en is low.
  always_comb begin
    case (state)
      CMD:     st = 2'b00;
      EVEN:    st = 2'b01;
      ODD:     st = 2'b10;
      default: st = 2'b11;
    endcase
  end

  // Next poll address: first set mask bit above the current one, wrapping 15 -> 0.
  always_comb begin
    nextPollAddr = pollAddr;
    found        = 1'b0;
    cand         = 4'd0;
    for (int i = 1; i < 16; i++) begin
      cand = pollAddr + 4'(i);
      if (!found && poll_mask[cand]) begin
        nextPollAddr = cand;
        found        = 1'b1;
      end
    end
  end

  // Transaction sequencer: command phase, two data phases, one-cycle response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      viaBusy        <= 1'b1;
      adb_din        <= 8'd0;
      adb_din_strobe <= 1'b0;
      resp_valid     <= 1'b0;
      resp_data      <= 16'd0;
      resp_len       <= 2'd0;
      resp_timeout   <= 1'b0;
      resp_srq       <= 1'b0;
      resp_auto      <= 1'b0;
      pollAddr       <= 4'd3;
      idleCnt        <= '0;
      phaseCnt       <= '0;
      dataReg        <= 16'd0;
      listenTxn      <= 1'b0;
      talkTxn        <= 1'b0;
      gotByte        <= 1'b0;
    end else if (clk_en) begin
      adb_din_strobe <= 1'b0;
      resp_valid     <= 1'b0;
      case (state)
        IDLE: begin
          viaBusy <= 1'b1;
          if (startTxn) begin
            dataReg        <= req_data;
            listenTxn      <= (startCmd[3:2] == 2'b10);
            talkTxn        <= (startCmd[3:2] == 2'b11);
            adb_din        <= startCmd;
            adb_din_strobe <= 1'b1;
            resp_data      <= 16'd0;
            resp_len       <= 2'd0;
            resp_timeout   <= 1'b0;
            resp_srq       <= 1'b0;
            resp_auto      <= !req_valid;
            idleCnt        <= '0;
            phaseCnt       <= '0;
            gotByte        <= 1'b0;
            state          <= CMD;
          end else if (idleCnt != pollLast) begin
            idleCnt <= idleCnt + IW'(1);
          end
        end
        CMD: begin
          if (phaseCnt == phaseLast) begin
            phaseCnt <= '0;
            gotByte  <= 1'b0;
            viaBusy  <= listenTxn;
            state    <= EVEN;
          end else begin
            phaseCnt <= phaseCnt + PW'(1);
          end
        end
        EVEN, ODD: begin
          if (!adb_int_n) resp_srq <= 1'b1;
          if (listenTxn) begin
            // Listen: host drives one payload byte per phase, on the phase's second cycle.
            if (phaseCnt == '0) begin
              adb_din        <= (state == EVEN) ? dataReg[15:8] : dataReg[7:0];
              adb_din_strobe <= 1'b1;
            end
            if (phaseCnt == phaseLast) begin
              phaseCnt <= '0;
              if (state == EVEN) begin
                state <= ODD;
              end else begin
                state      <= DONE;
                resp_valid <= 1'b1;
              end
            end else begin
              phaseCnt <= phaseCnt + PW'(1);
            end
          end else if (gotByte) begin
            // Byte taken last cycle; move on to the next phase.
            gotByte  <= 1'b0;
            phaseCnt <= '0;
            if (state == EVEN) begin
              viaBusy <= 1'b0;
              state   <= ODD;
            end else begin
              viaBusy    <= 1'b1;
              state      <= DONE;
              resp_valid <= 1'b1;
            end
          end else if (adb_dout_strobe) begin
            gotByte <= 1'b1;
            viaBusy <= 1'b1;
            // Reset/flush replies are consumed for pacing but never reported.
            if (talkTxn) begin
              if (state == EVEN) resp_data[15:8] <= adb_dout;
              else               resp_data[7:0]  <= adb_dout;
              resp_len <= resp_len + 2'd1;
            end
          end else if (phaseCnt == timeoutLast) begin
            // A missing byte ends the transaction; an EVEN timeout skips ODD entirely.
            resp_timeout <= 1'b1;
            viaBusy      <= 1'b1;
            phaseCnt     <= '0;
            state        <= DONE;
            resp_valid   <= 1'b1;
          end else begin
            phaseCnt <= phaseCnt + PW'(1);
          end
        end
        DONE: begin
          if (resp_auto && resp_srq) pollAddr <= nextPollAddr;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/adb_host_seq.md
# adb_host_seq

ADB host-side transaction sequencer that drives the `adb` device model the way the VIA shift-register firmware path does.
- Generates the `st[1:0]` state sequence, command and listen bytes, byte strobes and `viaBusy`.
- Collects Talk replies and samples the SRQ (`_int`).
- Runs an autopoll loop, so keyboard/mouse traffic works without ROM ADB support (debug/OSD path, boot-time probing).

## Interface
Parameters:
- PHASE_LEN, 16: clk_en cycles each non-idle phase (CMD, EVEN, ODD) lasts before advancing, when no earlier advance condition applies.
- TIMEOUT, 64: clk_en cycles EVEN/ODD waits for a Talk byte before declaring timeout; must be greater than PHASE_LEN.
- POLL_INTERVAL, 88000: idle clk_en cycles between autopolls (11 ms at 8 MHz enable).

Ports:
- clk  in  1  system clock
- clk_en  in  1  clock enable; all state, counters and outputs advance only when high
- reset  in  1  synchronous, active-high
- req_valid  in  1  host request present
- req_ready  out  1  high in IDLE; request accepted when req_valid & req_ready & clk_en
- req_cmd  in  8  ADB command byte {addr[3:0], cmd[3:0]}: 0000 reset, 0001 flush, 10rr listen, 11rr talk
- req_data  in  16  listen payload; [15:8] sent first
- resp_valid  out  1  one-clk_en-cycle pulse at transaction end
- resp_data  out  16  Talk bytes; first byte in [15:8]
- resp_len  out  2  Talk bytes received (0–2)
- resp_timeout  out  1  a Talk byte was missing
- resp_srq  out  1  `_int` seen low during transaction
- resp_auto  out  1  transaction was an autopoll
- autopoll_en  in  1  enable autopoll
- poll_mask  in  16  addresses eligible for SRQ-driven rotation
- st  out  2  to adb st
- viaBusy  out  1  to adb viaBusy
- adb_din  out  8  to adb adb_din
- adb_din_strobe  out  1  to adb adb_din_strobe
- adb_dout  in  8  from adb
- adb_dout_strobe  in  1  from adb
- adb_int_n  in  1  from adb `_int` (active low)

## Operation
States: IDLE(st=11), CMD(st=00), EVEN(st=01), ODD(st=10), DONE(st=11).

Reset values:
- state=IDLE, st=11, viaBusy=1, adb_din=0, adb_din_strobe=0.
- resp_* =0; poll_addr=3 (mouse); idle counter=0.

IDLE:
- Idle counter increments.
- A host request has priority. Latch req_cmd/req_data, clear idle counter, go CMD.
- Otherwise, if autopoll_en and idle counter reaches POLL_INTERVAL-1: issue Talk R0 {poll_addr,1100} with resp_auto=1, go CMD.

CMD:
- On the first clk_en cycle, adb_din=command byte with adb_din_strobe=1 for that single cycle.
- After PHASE_LEN clk_en cycles, go EVEN.
- Reset/flush continue through EVEN and ODD like Talk; any returned bytes are discarded and resp_len=0.

EVEN and ODD for Talk, reset and flush:
- viaBusy=0 while waiting.
- On adb_dout_strobe: capture the byte (EVEN→resp_data[15:8], ODD→[7:0]), increment len, set viaBusy=1, advance next clk_en cycle.
- After TIMEOUT cycles without a byte: set resp_timeout, advance.
- A timeout in EVEN skips ODD and goes to DONE.

EVEN and ODD for Listen:
- viaBusy=1.
- On the 2nd clk_en cycle of the phase, adb_din=req_data[15:8] (EVEN) or [7:0] (ODD) with a one-cycle strobe.
- Advance after PHASE_LEN cycles.

resp_srq:
- Set if adb_int_n=0 on any clk_en cycle in EVEN or ODD.

DONE:
- One cycle: resp_valid=1.
- If autopoll and resp_srq, rotate poll_addr to the next set bit of poll_mask above it, wrapping at 15→0.
- If the mask is empty or poll_addr is the only set bit, poll_addr stays.
- Return to IDLE.

Auto Talk with resp_len=2 and no SRQ keeps poll_addr.

## Timing
- All counts are in clk_en cycles. With clk_en=0, outputs hold and strobes stay asserted until the next clk_en cycle.
- Request acceptance to st=00: next clk_en cycle. adb_din_strobe is in that same cycle.
- Listen transaction: 3·PHASE_LEN+1 cycles, accept to resp_valid.
- Talk with prompt replies: CMD PHASE_LEN, then 2 cycles per byte plus device latency.
- A Talk to an absent address ends after PHASE_LEN+TIMEOUT+1 cycles (EVEN timeout path).
- req_valid arriving in the same cycle the autopoll fires: the host request wins and the idle counter clears.
- Reset mid-transaction: return to IDLE with st=11 and no resp_valid.
- adb_dout_strobe outside EVEN/ODD is ignored.

## Test plan
- Talk R3 to keyboard, req_cmd=8'h2F → resp_valid with resp_data=16'h6202, resp_len=2, resp_timeout=0, resp_srq=0.
- Listen R2 to keyboard, req_cmd=8'h2A, req_data=16'h0005 → two adb_din_strobes, the second with adb_din=8'h05; a following Talk R2 (8'h2E) returns [2:0]=3'b101.
- Talk R0 to addr 7, req_cmd=8'h7C → resp_len=0, resp_timeout=1, resp_valid exactly PHASE_LEN+TIMEOUT+1 cycles after accept.
- autopoll_en=1, poll_mask=16'h000C, key pressed with no mouse motion → auto Talk R0 at addr 3 sees resp_srq=1, poll_addr→2; the next autopoll returns the key code in resp_data[14:8].
- Host req_valid asserted in the cycle the autopoll would fire → the host command is issued, resp_auto=0.
- Reset asserted during ODD of a Talk → next clk_en: st=11, req_ready=1, no resp_valid; a subsequent Talk completes normally.
